// File: rtl/mdu_controller_pkg.sv
// Shared encodings, latency defaults and op-class helpers for the multiply/divide unit.
// MDU_MADD_EN enables the madd/maddu accumulate ops (codes 7/8).
package mdu_controller_pkg;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) || (op == MD_MADDU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: one 33x33 signed multiplier and a sign-magnitude divider.
// MDU_MADD_EN adds the 64-bit accumulate path for madd/maddu.
module mdu_arith
    import mdu_controller_pkg::*;
(
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic               sgn_s;
    logic signed [32:0] mul_a_s;
    logic signed [32:0] mul_b_s;
    logic signed [65:0] prod_s;
    logic               dvd_neg_s;
    logic               dvs_neg_s;
    logic [31:0]        dvd_mag_s;
    logic [31:0]        dvs_mag_s;
    logic [31:0]        dvs_safe_s;
    logic [31:0]        q_mag_s;
    logic [31:0]        r_mag_s;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic               unused_s;

    // Multiply and divide paths; a zero divisor is swapped for 1 so the divider never sees it.
    always_comb begin
        sgn_s      = is_signed_op(md_op);
        mul_a_s    = {sgn_s & rs_val[31], rs_val};
        mul_b_s    = {sgn_s & rt_val[31], rt_val};
        prod_s     = 66'(mul_a_s) * 66'(mul_b_s);
        dvd_neg_s  = sgn_s & rs_val[31];
        dvs_neg_s  = sgn_s & rt_val[31];
        dvd_mag_s  = dvd_neg_s ? (32'd0 - rs_val) : rs_val;
        dvs_mag_s  = dvs_neg_s ? (32'd0 - rt_val) : rt_val;
        dvs_safe_s = (rt_val == 32'd0) ? 32'd1 : dvs_mag_s;
        q_mag_s    = dvd_mag_s / dvs_safe_s;
        r_mag_s    = dvd_mag_s % dvs_safe_s;
        quot_s     = (dvd_neg_s ^ dvs_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
        rem_s      = dvd_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
    end

    // Result select by operation class.
    always_comb begin
        result      = 64'd0;
        div_by_zero = is_div_op(md_op) && (rt_val == 32'd0);
        case (md_op)
            MD_MULT, MD_MULTU: result = prod_s[63:0];
            MD_DIV,  MD_DIVU:  result = {rem_s, quot_s};
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: result = {hi, lo} + prod_s[63:0];
`endif
            default:           result = 64'd0;
        endcase
    end

`ifdef MDU_MADD_EN
    assign unused_s = ^prod_s[65:64];
`else
    assign unused_s = ^{prod_s[65:64], hi, lo};
`endif

endmodule

// File: rtl/mdu_controller.sv
// Multi-cycle multiply/divide sequencer holding HI/LO and raising the D-stage stall request.
// Optional madd/maddu support is enabled by defining MDU_MADD_EN.
module mdu_controller
    import mdu_controller_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_sel,
    input  logic        d_is_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data,
    output logic        stall_req
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

    mdu_state_e  state_r;
    mdu_state_e  state_s;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [63:0] shadow_r;
    logic        shadow_dbz_r;
    logic [63:0] arith_result_s;
    logic        arith_dbz_s;
    logic        start_long_s;
    logic        load_s;
    logic        commit_s;
    logic        wr_hi_s;
    logic        wr_lo_s;
    logic [3:0]  cnt_load_s;

    mdu_arith u_arith (
        .md_op       (md_op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .hi          (hi_r),
        .lo          (lo_r),
        .result      (arith_result_s),
        .div_by_zero (arith_dbz_s)
    );

    assign start_long_s = start & (is_mul_op(md_op) | is_div_op(md_op));

    // State register; busy is registered alongside so it mirrors RUN without a decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_RUN);
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_long_s) state_s = ST_RUN;
                else              state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_r == 4'd1) state_s = ST_IDLE;
                else               state_s = ST_RUN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Control decode; a divide by zero still runs its full latency but never commits.
    always_comb begin
        load_s     = 1'b0;
        commit_s   = 1'b0;
        wr_hi_s    = 1'b0;
        wr_lo_s    = 1'b0;
        cnt_load_s = is_div_op(md_op) ? DIV_CNT : MUL_CNT;
        case (state_r)
            ST_IDLE: begin
                load_s  = start_long_s;
                wr_hi_s = start & (md_op == MD_MTHI);
                wr_lo_s = start & (md_op == MD_MTLO);
            end
            ST_RUN: begin
                commit_s = (cnt_r == 4'd1) & ~shadow_dbz_r;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Latency counter and shadow result captured on the start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r        <= 4'd0;
            shadow_r     <= 64'd0;
            shadow_dbz_r <= 1'b0;
        end else if (load_s) begin
            cnt_r        <= cnt_load_s;
            shadow_r     <= arith_result_s;
            shadow_dbz_r <= arith_dbz_s;
        end else if (state_r == ST_RUN) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Architectural HI/LO: committed result or direct mthi/mtlo writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (commit_s) begin
            hi_r <= shadow_r[63:32];
            lo_r <= shadow_r[31:0];
        end else begin
            if (wr_hi_s) hi_r <= rs_val;
            if (wr_lo_s) lo_r <= rs_val;
        end
    end

    assign busy      = busy_r;
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign rd_data   = rd_sel ? hi_r : lo_r;
    assign stall_req = d_is_md & (busy_r | start_long_s);

endmodule

// File: tb/tb_mdu_controller.sv
// Randomized self-checking bench for mdu_controller against a cycle-level arithmetic model.
// Honours MDU_MADD_EN to match the build under test.
module tb_mdu_controller;

    logic        clk = 1'b0;
    logic        reset, start, rd_sel, d_is_md;
    logic [3:0]  md_op;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall_req;
    logic [31:0] hi, lo, rd_data;

    int vectors = 0;
    int miscompares = 0;
    int stall_cnt = 0;

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;
    bit          p_commit;

`ifdef MDU_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    mdu_controller dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .rd_sel(rd_sel), .d_is_md(d_is_md),
        .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data), .stall_req(stall_req)
    );

    function automatic bit long_op(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (MADD_ON && (op == 4'd7 || op == 4'd8));
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Model: one clock edge applied with the current inputs.
    task automatic model_edge();
        longint sa, sb, ua, ub;
        logic [63:0] full;
        logic [63:0] q, r;
        if (reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0; p_commit = 1'b0;
            p_hi = 32'd0; p_lo = 32'd0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_commit) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (start) begin
            sa = longint'($signed(rs_val));
            sb = longint'($signed(rt_val));
            ua = longint'({32'd0, rs_val});
            ub = longint'({32'd0, rt_val});
            full = 64'd0;
            p_commit = 1'b1;
            case (md_op)
                4'd1: begin full = sa * sb; m_left = 5; end
                4'd2: begin full = ua * ub; m_left = 5; end
                4'd3, 4'd4: begin
                    m_left = 10;
                    if (rt_val == 32'd0) p_commit = 1'b0;
                    else if (md_op == 4'd3) begin q = sa / sb; r = sa % sb; full = {r[31:0], q[31:0]}; end
                    else begin q = ua / ub; r = ua % ub; full = {r[31:0], q[31:0]}; end
                end
                4'd5: m_hi = rs_val;
                4'd6: m_lo = rs_val;
                4'd7: if (MADD_ON) begin full = {m_hi, m_lo} + 64'(sa * sb); m_left = 5; end
                4'd8: if (MADD_ON) begin full = {m_hi, m_lo} + 64'(ua * ub); m_left = 5; end
                default: ;
            endcase
            p_hi = full[63:32];
            p_lo = full[31:0];
        end
    endtask

    // One cycle: drive, check combinational outputs, clock, check registered outputs.
    task automatic step(input bit r, input bit s, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit dm, input bit sel);
        reset = r; start = s; md_op = op; rs_val = a; rt_val = b; d_is_md = dm; rd_sel = sel;
        #1;
        check1("stall_req", stall_req, dm & ((m_left > 0) | (s & long_op(op))));
        check32("rd_data", rd_data, sel ? m_hi : m_lo);
        if (s && !r) check1("start_in_run", busy, 1'b0);
        if (stall_req) stall_cnt++;
        @(posedge clk);
        model_edge();
        #1;
        check1("busy", busy, m_left > 0);
        check32("hi", hi, m_hi);
        check32("lo", lo, m_lo);
    endtask

    task automatic idle(input bit dm);
        step(1'b0, 1'b0, 4'd0, $urandom, $urandom, dm, 1'($urandom));
    endtask

    // Issue one op and run it out, checking the busy pulse length against a literal.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit dm, input int exp_busy);
        int n = 0;
        int guard = 0;
        step(1'b0, 1'b1, op, a, b, dm, 1'b0);
        if (busy) n++;
        while (m_left > 0 && guard < 20) begin
            idle(dm);
            if (busy) n++;
            guard++;
        end
        if (m_left > 0) check1("op_timeout", 1'b1, 1'b0);
        check32("busy_len", 32'(n), 32'(exp_busy));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7, 0))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
        d_is_md = 1'b0; rd_sel = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check1("reset_busy", busy, 1'b0);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 5);
        check32("mult_hi", hi, 32'hFFFF_FFFF);
        check32("mult_lo", lo, 32'hFFFF_FFFA);

        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 5);
        check32("multu_hi", hi, 32'h0000_0002);
        check32("multu_lo", lo, 32'hFFFF_FFFA);

        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 10);
        check32("div_lo", lo, 32'hFFFF_FFFD);
        check32("div_hi", hi, 32'hFFFF_FFFF);

        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10);
        check32("divovf_lo", lo, 32'h8000_0000);
        check32("divovf_hi", hi, 32'h0000_0000);

        step(1'b0, 1'b1, 4'd6, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd5, 32'h0000_5678, 32'd0, 1'b0, 1'b0);
        run_op(4'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, 10);
        check32("divz_hi", hi, 32'h0000_5678);
        check32("divz_lo", lo, 32'h0000_1234);

        stall_cnt = 0;
        run_op(4'd3, 32'd100, 32'd7, 1'b1, 10);
        idle(1'b1);
        check32("stall_cycles_dm1", 32'(stall_cnt), 32'd11);
        stall_cnt = 0;
        run_op(4'd3, 32'd100, 32'd7, 1'b0, 10);
        check32("stall_cycles_dm0", 32'(stall_cnt), 32'd0);

        step(1'b0, 1'b1, 4'd1, 32'd1000, 32'd1000, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check1("rst_mid_busy", busy, 1'b0);
        check32("rst_mid_hi", hi, 32'd0);
        check32("rst_mid_lo", lo, 32'd0);
        step(1'b0, 1'b1, 4'd6, 32'h0000_ABCD, 32'd0, 1'b0, 1'b0);
        check32("mtlo_after_rst", lo, 32'h0000_ABCD);

        step(1'b0, 1'b1, 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        run_op(4'd7, 32'd1, 32'd1, 1'b0, MADD_ON ? 5 : 0);
        check32("madd_hi", hi, MADD_ON ? 32'd1 : 32'd0);
        check32("madd_lo", lo, MADD_ON ? 32'd0 : 32'hFFFF_FFFF);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99, 0) == 0)
                step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'($urandom), 1'($urandom));
            else if (m_left == 0 && $urandom_range(2, 0) == 0)
                step(1'b0, 1'b1, 4'($urandom_range(15, 0)), pick(), pick(),
                     1'($urandom), 1'($urandom));
            else
                step(1'b0, 1'b0, 4'($urandom_range(15, 0)), $urandom, $urandom,
                     1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
